// File: rtl/stopwatch_if.sv
// stopwatch_if: button pulses, live time in, counter controls and display out
interface stopwatch_if #(parameter int LAP_DEPTH = 4) ();
  localparam int CW = $clog2(LAP_DEPTH + 1);
  localparam int IW = LAP_DEPTH > 1 ? $clog2(LAP_DEPTH) : 1;
  logic          start_p;
  logic          lap_p;
  logic          clear_p;
  logic [23:0]   live_hms;
  logic [11:0]   live_milli;
  logic          start_stop;
  logic          clr_n;
  logic [23:0]   disp_hms;
  logic [11:0]   disp_milli;
  logic [1:0]    state_o;
  logic [CW-1:0] lap_count;
  logic [IW-1:0] lap_idx;
  logic          lap_ovf;
  modport master (
    output start_p, lap_p, clear_p, live_hms, live_milli,
    input  start_stop, clr_n, disp_hms, disp_milli, state_o, lap_count, lap_idx, lap_ovf
  );
  modport slave (
    input  start_p, lap_p, clear_p, live_hms, live_milli,
    output start_stop, clr_n, disp_hms, disp_milli, state_o, lap_count, lap_idx, lap_ovf
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear sequencer with lap buffer and display mux
module stopwatch_ctrl #(
  parameter int LAP_DEPTH   = 4,
  parameter int HOLD_CYCLES = 2000
) (
  input logic        clk_in,
  input logic        resetn,
  stopwatch_if.slave bus
);
  localparam int CW = $clog2(LAP_DEPTH + 1);
  localparam int IW = LAP_DEPTH > 1 ? $clog2(LAP_DEPTH) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, REVIEW = 2'd3} state_t;
  state_t        state, state_nx;
  logic          do_clear, do_start, do_lap, cap, full, last;
  logic [CW-1:0] count_q, count_nx;
  logic [IW-1:0] idx_q, idx_nx;
  logic          ovf_q, ovf_nx;
  logic [HW-1:0] hold_q, hold_nx;
  logic [35:0]   live, held_q, held_nx, disp_q, disp_nx;
  logic          run_q, clr_n_q;
  logic [35:0]   laps [LAP_DEPTH];
  assign live     = {bus.live_hms, bus.live_milli};
  // clear is only honoured outside RUN; a dropped clear does not mask lap
  assign do_clear = bus.clear_p && state != RUN;
  assign do_start = bus.start_p && !do_clear;
  assign do_lap   = bus.lap_p && !bus.start_p && !do_clear;
  assign cap      = do_lap && state == RUN;
  assign full     = count_q == CW'(LAP_DEPTH);
  assign last     = CW'(idx_q) == count_q - CW'(1);
  always_ff @(posedge clk_in) begin
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = do_clear ? IDLE :
               do_start ? ((state == IDLE || state == PAUSE) ? RUN : PAUSE) :
               (do_lap && state == PAUSE && count_q != '0) ? REVIEW : state;
  end
  // display selects use next-state values so a capture shows the cycle after its edge
  always_comb begin
    count_nx = do_clear ? '0 : (cap && !full) ? count_q + CW'(1) : count_q;
    ovf_nx   = !do_clear && (ovf_q || (cap && full));
    idx_nx   = (do_clear || (do_lap && state == PAUSE)) ? '0 :
               (do_lap && state == REVIEW) ? (last ? '0 : idx_q + IW'(1)) : idx_q;
    hold_nx  = state_nx != RUN ? '0 : cap ? HW'(HOLD_CYCLES) : hold_q != '0 ? hold_q - HW'(1) : hold_q;
    held_nx  = cap ? live : held_q;
    disp_nx  = state_nx == REVIEW ? laps[idx_nx] :
               (state_nx == RUN && hold_nx != '0) ? held_nx : live;
  end
  always_ff @(posedge clk_in) begin
    if (!resetn) begin
      run_q   <= 1'b0;
      clr_n_q <= 1'b0;
      count_q <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      hold_q  <= '0;
      disp_q  <= live;
    end else begin
      run_q   <= state_nx == RUN;
      clr_n_q <= !do_clear;
      count_q <= count_nx;
      idx_q   <= idx_nx;
      ovf_q   <= ovf_nx;
      hold_q  <= hold_nx;
      disp_q  <= disp_nx;
    end
  end
  always_ff @(posedge clk_in) begin
    held_q <= held_nx;
    if (cap && !full) laps[IW'(count_q)] <= live;
  end
  assign bus.start_stop = run_q;
  assign bus.clr_n      = clr_n_q;
  assign bus.disp_hms   = disp_q[35:12];
  assign bus.disp_milli = disp_q[11:0];
  assign bus.state_o    = state;
  assign bus.lap_count  = count_q;
  assign bus.lap_idx    = idx_q;
  assign bus.lap_ovf    = ovf_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scenario tasks with a queue of expected lap captures
module tb_stopwatch_ctrl;
  localparam int LD = 4;
  localparam int HC = 20;
  logic clk_in = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];
  stopwatch_if #(.LAP_DEPTH(LD)) bus ();
  stopwatch_ctrl #(.LAP_DEPTH(LD), .HOLD_CYCLES(HC)) dut (.clk_in(clk_in), .resetn(resetn), .bus(bus));
  always #5 clk_in = ~clk_in;
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  task automatic pulse(input logic s, input logic l, input logic c);
    bus.start_p = s;
    bus.lap_p = l;
    bus.clear_p = c;
    tick();
    bus.start_p = 1'b0;
    bus.lap_p = 1'b0;
    bus.clear_p = 1'b0;
  endtask
  task automatic test_reset;
    resetn = 1'b0;
    bus.start_p = 1'b0;
    bus.lap_p = 1'b0;
    bus.clear_p = 1'b0;
    bus.live_hms = 24'h0;
    bus.live_milli = 12'h0;
    tick();
    tick();
    checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", bus.state_o); end
    checks++; if (bus.start_stop !== 1'b0) begin errors++; $display("FAIL rst_start_stop got %b want 0", bus.start_stop); end
    checks++; if (bus.clr_n !== 1'b0) begin errors++; $display("FAIL rst_clr_n got %b want 0", bus.clr_n); end
    checks++; if (bus.lap_count !== 3'd0) begin errors++; $display("FAIL rst_lap_count got %0d want 0", bus.lap_count); end
    checks++; if (bus.lap_idx !== 2'd0) begin errors++; $display("FAIL rst_lap_idx got %0d want 0", bus.lap_idx); end
    checks++; if (bus.lap_ovf !== 1'b0) begin errors++; $display("FAIL rst_lap_ovf got %b want 0", bus.lap_ovf); end
    resetn = 1'b1;
    tick();
    checks++; if (bus.clr_n !== 1'b1) begin errors++; $display("FAIL rst_release_clr_n got %b want 1", bus.clr_n); end
  endtask
  task automatic test_idle;
    pulse(1'b0, 1'b1, 1'b0);
    checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL idle_lap_state got %0d want 0", bus.state_o); end
    checks++; if (bus.lap_count !== 3'd0) begin errors++; $display("FAIL idle_lap_count got %0d want 0", bus.lap_count); end
    pulse(1'b0, 1'b0, 1'b1);
    checks++; if (bus.clr_n !== 1'b0) begin errors++; $display("FAIL idle_clear_clr_n got %b want 0", bus.clr_n); end
    checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL idle_clear_state got %0d want 0", bus.state_o); end
    tick();
    checks++; if (bus.clr_n !== 1'b1) begin errors++; $display("FAIL idle_clear_release got %b want 1", bus.clr_n); end
  endtask
  task automatic test_run_pause;
    int cnt;
    logic clr_ok;
    cnt = 0;
    clr_ok = 1'b1;
    bus.live_hms = 24'h010203;
    bus.live_milli = 12'h100;
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL run_state got %0d want 1", bus.state_o); end
    for (int i = 0; i < 50; i++) begin
      if (bus.start_stop === 1'b1) cnt++;
      if (bus.clr_n !== 1'b1) clr_ok = 1'b0;
      if (i == 49) bus.start_p = 1'b1;
      tick();
      bus.start_p = 1'b0;
    end
    checks++; if (cnt != 50) begin errors++; $display("FAIL run_high_cycles got %0d want 50", cnt); end
    checks++; if (clr_ok !== 1'b1) begin errors++; $display("FAIL run_clr_n_steady got %b want 1", clr_ok); end
    checks++; if (bus.state_o !== 2'd2) begin errors++; $display("FAIL pause_state got %0d want 2", bus.state_o); end
    checks++; if (bus.start_stop !== 1'b0) begin errors++; $display("FAIL pause_start_stop got %b want 0", bus.start_stop); end
    pulse(1'b0, 1'b1, 1'b0);
    checks++; if (bus.state_o !== 2'd2) begin errors++; $display("FAIL pause_empty_review got %0d want 2", bus.state_o); end
  endtask
  task automatic test_hold;
    int cnt;
    cnt = 0;
    pulse(1'b1, 1'b0, 1'b0);
    bus.live_hms = 24'h000001;
    bus.live_milli = 12'h345;
    pulse(1'b0, 1'b1, 1'b0);
    exp_q.push_back({24'h000001, 12'h345});
    bus.live_milli = 12'h111;
    checks++; if (bus.lap_count !== 3'd1) begin errors++; $display("FAIL hold_lap_count got %0d want 1", bus.lap_count); end
    for (int i = 0; i < HC + 3; i++) begin
      if (bus.disp_milli === 12'h345) cnt++;
      tick();
    end
    checks++; if (cnt != HC) begin errors++; $display("FAIL hold_cycles got %0d want %0d", cnt, HC); end
    checks++; if (bus.disp_milli !== 12'h111) begin errors++; $display("FAIL hold_back_live got %h want 111", bus.disp_milli); end
  endtask
  task automatic test_clear_run;
    pulse(1'b0, 1'b0, 1'b1);
    checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL clear_run_state got %0d want 1", bus.state_o); end
    checks++; if (bus.clr_n !== 1'b1) begin errors++; $display("FAIL clear_run_clr_n got %b want 1", bus.clr_n); end
    checks++; if (bus.lap_count !== 3'd1) begin errors++; $display("FAIL clear_run_count got %0d want 1", bus.lap_count); end
  endtask
  task automatic test_review;
    logic [35:0] e;
    bus.live_hms = 24'h000002;
    bus.live_milli = 12'h222;
    pulse(1'b0, 1'b1, 1'b0);
    exp_q.push_back({24'h000002, 12'h222});
    tick();
    bus.live_hms = 24'h000003;
    bus.live_milli = 12'h333;
    pulse(1'b0, 1'b1, 1'b0);
    exp_q.push_back({24'h000003, 12'h333});
    bus.live_milli = 12'h999;
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (bus.state_o !== 2'd2) begin errors++; $display("FAIL review_pause_state got %0d want 2", bus.state_o); end
    checks++; if (bus.disp_milli !== 12'h999) begin errors++; $display("FAIL review_pause_live got %h want 999", bus.disp_milli); end
    for (int i = 0; i < 4; i++) begin
      pulse(1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      exp_q.push_back(e);
      checks++; if (bus.state_o !== 2'd3) begin errors++; $display("FAIL review_state[%0d] got %0d want 3", i, bus.state_o); end
      checks++; if (bus.lap_idx !== 2'(i % 3)) begin errors++; $display("FAIL review_idx[%0d] got %0d want %0d", i, bus.lap_idx, i % 3); end
      checks++; if ({bus.disp_hms, bus.disp_milli} !== e) begin errors++; $display("FAIL review_disp[%0d] got %h want %h", i, {bus.disp_hms, bus.disp_milli}, e); end
    end
    bus.live_milli = 12'habc;
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (bus.state_o !== 2'd2) begin errors++; $display("FAIL review_exit_state got %0d want 2", bus.state_o); end
    checks++; if (bus.disp_milli !== 12'habc) begin errors++; $display("FAIL review_exit_live got %h want abc", bus.disp_milli); end
  endtask
  task automatic test_clear_pause;
    pulse(1'b1, 1'b0, 1'b1);
    exp_q.delete();
    checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL clear_pause_state got %0d want 0", bus.state_o); end
    checks++; if (bus.clr_n !== 1'b0) begin errors++; $display("FAIL clear_pause_clr_n got %b want 0", bus.clr_n); end
    checks++; if (bus.lap_count !== 3'd0) begin errors++; $display("FAIL clear_pause_count got %0d want 0", bus.lap_count); end
    checks++; if (bus.start_stop !== 1'b0) begin errors++; $display("FAIL clear_pause_start_stop got %b want 0", bus.start_stop); end
    tick();
    checks++; if (bus.clr_n !== 1'b1) begin errors++; $display("FAIL clear_pause_release got %b want 1", bus.clr_n); end
  endtask
  task automatic test_overflow;
    logic [35:0] e;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < LD + 1; i++) begin
      e = {24'h100000 + 24'(i), 12'h500 + 12'(i)};
      {bus.live_hms, bus.live_milli} = e;
      if (i < LD) exp_q.push_back(e);
      pulse(1'b0, 1'b1, 1'b0);
      bus.live_milli = 12'hfff;
      tick();
    end
    checks++; if (bus.lap_count !== 3'(LD)) begin errors++; $display("FAIL ovf_count got %0d want %0d", bus.lap_count, LD); end
    checks++; if (bus.lap_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.lap_ovf); end
    checks++; if (bus.disp_milli !== 12'h504) begin errors++; $display("FAIL ovf_hold_disp got %h want 504", bus.disp_milli); end
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < LD + 1; i++) begin
      pulse(1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      exp_q.push_back(e);
      checks++; if (bus.lap_idx !== 2'(i % LD)) begin errors++; $display("FAIL ovf_idx[%0d] got %0d want %0d", i, bus.lap_idx, i % LD); end
      checks++; if ({bus.disp_hms, bus.disp_milli} !== e) begin errors++; $display("FAIL ovf_entry[%0d] got %h want %h", i, {bus.disp_hms, bus.disp_milli}, e); end
    end
    pulse(1'b0, 1'b0, 1'b1);
    exp_q.delete();
    checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL review_clear_state got %0d want 0", bus.state_o); end
    checks++; if (bus.lap_count !== 3'd0) begin errors++; $display("FAIL review_clear_count got %0d want 0", bus.lap_count); end
    checks++; if (bus.lap_ovf !== 1'b0) begin errors++; $display("FAIL review_clear_ovf got %b want 0", bus.lap_ovf); end
    checks++; if (bus.clr_n !== 1'b0) begin errors++; $display("FAIL review_clear_clr_n got %b want 0", bus.clr_n); end
    tick();
  endtask
  task automatic test_reset_midrun;
    pulse(1'b1, 1'b0, 1'b0);
    bus.live_milli = 12'h777;
    pulse(1'b0, 1'b1, 1'b0);
    bus.live_milli = 12'h888;
    tick();
    checks++; if (bus.disp_milli !== 12'h777) begin errors++; $display("FAIL midrun_held got %h want 777", bus.disp_milli); end
    resetn = 1'b0;
    tick();
    checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL midrun_rst_state got %0d want 0", bus.state_o); end
    checks++; if (bus.start_stop !== 1'b0) begin errors++; $display("FAIL midrun_rst_start_stop got %b want 0", bus.start_stop); end
    checks++; if (bus.clr_n !== 1'b0) begin errors++; $display("FAIL midrun_rst_clr_n got %b want 0", bus.clr_n); end
    checks++; if (bus.lap_count !== 3'd0) begin errors++; $display("FAIL midrun_rst_count got %0d want 0", bus.lap_count); end
    checks++; if (bus.disp_milli !== 12'h888) begin errors++; $display("FAIL midrun_rst_disp got %h want 888", bus.disp_milli); end
    resetn = 1'b1;
    tick();
    checks++; if (bus.clr_n !== 1'b1) begin errors++; $display("FAIL midrun_release_clr_n got %b want 1", bus.clr_n); end
  endtask
  initial begin
    test_reset();
    test_idle();
    test_run_pause();
    test_hold();
    test_clear_run();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    test_review();
    test_clear_pause();
    test_overflow();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Run/pause/clear sequencer for the BCD stopwatch counter (hh:mm:ss + 3-digit BCD milliseconds).
- Turns single-cycle button pulses into the counter's run-enable and clear.
- Captures lap times into a small buffer and drives a display mux: live time, a frozen lap for a hold period, or lap review.
- Sits between the debounced button logic and the counter/display path, on the counter's clock.

Parameters:
LAP_DEPTH, 4, number of lap entries stored (>=1)
HOLD_CYCLES, 2000, clk_in cycles the display stays frozen after a lap capture in RUN (>=1)

Ports:
clk_in  input  1  clock, same clock as the stopwatch counter
resetn  input  1  synchronous active-low reset
start_p  input  1  start/stop button pulse, one cycle wide
lap_p  input  1  lap/review button pulse, one cycle wide
clear_p  input  1  clear button pulse, one cycle wide
live_hms  input  24  live counter {hours, minutes, seconds}, BCD
live_milli  input  12  live counter milliseconds, BCD
start_stop  output  1  run enable to the counter
clr_n  output  1  active-low clear to the counter
disp_hms  output  24  displayed {hours, minutes, seconds}
disp_milli  output  12  displayed milliseconds
state_o  output  2  IDLE=0, RUN=1, PAUSE=2, REVIEW=3
lap_count  output  clog2(LAP_DEPTH+1)  number of stored laps
lap_idx  output  clog2(LAP_DEPTH)  lap index shown in REVIEW
lap_ovf  output  1  sticky flag: a lap was dropped because the buffer was full

Behaviour:
- Clock and reset: all registers update on posedge clk_in. resetn low sampled at an edge sets the reset state.
- Reset state:
  - state IDLE; start_stop 0; clr_n 0.
  - lap_count 0, lap_idx 0, lap_ovf 0; hold timer 0; lap buffer contents don't-care.
  - clr_n goes to 1 on the first edge with resetn high.
- Event priority when pulses coincide: clear_p > start_p > lap_p. Only the highest-priority event valid in the current state is acted on; lower ones are dropped.
- IDLE:
  - start_p -> RUN.
  - clear_p -> stays IDLE; clr_n 0 for exactly one cycle.
  - lap_p ignored.
- RUN:
  - start_p -> PAUSE.
  - clear_p ignored; the watch must be paused before it can be cleared.
  - lap_p, capture: {live_hms, live_milli} as sampled at that edge is written to entry lap_count, and lap_count increments.
  - lap_p, hold: the hold timer loads HOLD_CYCLES and the display shows the captured value from the next cycle.
  - lap_p with buffer full (lap_count==LAP_DEPTH): no write, lap_ovf set to 1; the hold still reloads with that capture shown.
  - Hold timer decrements each cycle while nonzero. The display returns to live when it reaches 0, i.e. exactly HOLD_CYCLES cycles of frozen display.
  - A new lap_p during a hold reloads the timer and shows the newer capture.
- PAUSE:
  - start_p -> RUN.
  - clear_p -> IDLE: clr_n 0 for one cycle; lap_count, lap_idx, lap_ovf and the hold timer cleared.
  - lap_p with lap_count>0 -> REVIEW, lap_idx 0; with lap_count==0, ignored.
  - Leaving RUN for PAUSE clears the hold timer, so the display is live.
- REVIEW:
  - lap_p -> lap_idx+1, wrapping to 0 after lap_count-1.
  - start_p -> PAUSE (lap_idx retained); the watch does not resume directly from REVIEW.
  - clear_p -> IDLE with the same clear actions as PAUSE.
- start_stop: registered; equals 1 exactly when state==RUN. It asserts the cycle after the start_p edge.
- clr_n: registered; 0 during reset and for the one cycle following an accepted clear_p, otherwise 1.
- Display mux (registered, one-cycle latency from its selects):
  - REVIEW: entry[lap_idx].
  - RUN with hold timer nonzero: the held capture.
  - Otherwise: live inputs.
- Inputs are passed through unmodified; the block never performs BCD arithmetic.

Test Plan:
- Reset, then start_p, wait 50 cycles, start_p -> start_stop high for exactly 50 cycles, state_o 1 then 2, clr_n 1 throughout.
- RUN, live_milli=12'h345 at lap_p -> disp_milli=345 for exactly HOLD_CYCLES cycles then tracks live; lap_count=1.
- RUN, LAP_DEPTH+1 lap_p pulses -> lap_count=4, lap_ovf=1, entries 0..3 hold the first four captures.
- PAUSE with 3 laps, lap_p x4 -> state 3, lap_idx 0,1,2,0, disp shows matching entries; start_p -> state 2, live display.
- Clear handling:
  - clear_p in RUN -> ignored.
  - clear_p in PAUSE -> clr_n low one cycle, state 0, lap_count 0, lap_ovf 0.
  - clear_p+start_p together in PAUSE -> clear wins.
- resetn low mid-RUN during a hold -> next edge: state 0, start_stop 0, clr_n 0, lap_count 0, display live.
